// File: rtl/uart_pkg.sv
// Purpose: shared UART constants and types for the RX byte path (and later the TX side).
// Latency: n/a, declarations only.
// Backpressure: n/a, declarations only.
// Contents: UART_BYTE_W, default FIFO depth (log2), default synchroniser length, byte type.
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int UART_DEPTH_LOG2_DEF  = 4;
  localparam int UART_SYNC_STAGES_DEF = 2;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Purpose: bundles the receiver-facing and host-facing signals of the RX byte FIFO.
// Latency: n/a, wiring only.
// Backpressure: none; a dropped byte is reported through the sticky overflow flag.
// Ports: master drives rxdata/dataok/rd_en/ovf_clr and observes status;
//        slave (the FIFO) drives rd_data/rd_valid/empty/full/count/overflow.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = uart_pkg::UART_DEPTH_LOG2_DEF
);
  import uart_pkg::*;

  uart_byte_t            rxdata;
  logic                  dataok;
  logic                  rd_en;
  logic                  ovf_clr;
  uart_byte_t            rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  modport master (
    output rxdata, dataok, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rxdata, dataok, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, overflow
  );

endinterface

// File: rtl/uart_sync_edge.sv
// Purpose: STAGES-flop synchroniser plus history flop; gives the synced level and a rising-edge pulse.
// Latency: input high sampled at edge N => rise is high during the cycle after edge N+STAGES-1.
// Backpressure: none; a level held high produces exactly one rise pulse.
// Ports: clk50m, reset_n (async, active-low), din (async level), level (synced), rise (1-cycle pulse).
module uart_sync_edge import uart_pkg::*; #(
  parameter int STAGES = UART_SYNC_STAGES_DEF
) (
  input  logic clk50m,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // All flops reset to 0, so an input already high at reset release
  // looks like a fresh rising edge.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: captures each UART byte once (dataok rising edge) into a circular FIFO read by the host.
// Latency: dataok seen at edge N => written at edge N+SYNC_STAGES; rd_en at edge M => rd_data/rd_valid after edge M.
// Backpressure: none upstream; a write into a full FIFO without a same-cycle read is dropped and sets sticky overflow.
// Ports: clk50m, reset_n (async, active-low), bus (slave: rxdata, dataok, rd_en, ovf_clr in;
//        rd_data, rd_valid, empty, full, count, overflow out).
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH_LOG2  = UART_DEPTH_LOG2_DEF,
  parameter int SYNC_STAGES = UART_SYNC_STAGES_DEF
) (
  input  logic          clk50m,
  input  logic          reset_n,
  uart_rx_fifo_if.slave bus
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam int                    CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  uart_byte_t            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  uart_byte_t            rd_data_q;
  logic                  rd_valid_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  overflow_q;

  logic wr;
  logic do_rd;
  logic do_wr;
  logic drop;
  logic dataok_lvl_unused;

  // The synced level is not needed on the RX side; only the edge pulse is used.
  uart_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .din     (bus.dataok),
    .level   (dataok_lvl_unused),
    .rise    (wr)
  );

  // A read always succeeds when not empty. When full, that read frees the
  // slot the incoming byte needs, so the write is accepted in the same cycle.
  assign do_rd = bus.rd_en & ~empty_q;
  assign do_wr = wr & (~full_q | do_rd);
  assign drop  = wr & full_q & ~bus.rd_en;

  always_comb begin
    count_nxt = count_q;
    if (do_wr && !do_rd) begin
      count_nxt = count_q + CNT_ONE;
    end else if (do_rd && !do_wr) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  // rxdata has been stable since before dataok rose, so it is sampled
  // directly on the write cycle. Storage contents need no reset.
  always_ff @(posedge clk50m) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.rxdata;
    end
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= do_rd;
      count_q    <= count_nxt;
      // Flags come from the next-state count so they stay aligned with count.
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == CNT_FULL);
      // A fresh drop beats a simultaneous clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: self-checking bench for uart_rx_fifo with a queue-based reference model and scoreboard.
// Latency: model applies writes SYNC_STAGES edges after dataok is first seen high.
// Backpressure: n/a.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int SYNC  = 2;

  logic clk50m  = 1'b0;
  logic reset_n = 1'b0;

  always #10 clk50m = ~clk50m;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2  (DL2),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // ---------------- reference model state ----------------
  logic [7:0] mq[$];        // bytes held by the FIFO
  logic [7:0] exp_rd[$];    // scoreboard: bytes expected on rd_data
  longint     pend_at[$];   // edge number at which a pending write lands
  logic [7:0] pend_d[$];
  longint     edge_no   = 0;
  bit         m_rdv     = 1'b0;
  logic [7:0] mlast     = 8'h00;
  bit         movf      = 1'b0;
  bit         mlast_dok = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int hold, input int gap);
    bus.rxdata = d;
    bus.dataok = 1'b1;
    tick(hold);
    bus.dataok = 1'b0;
    tick(gap);
  endtask

  task automatic read_n(input int n);
    bus.rd_en = 1'b1;
    tick(n);
    bus.rd_en = 1'b0;
  endtask

  // Model: one byte per dataok rising edge, landing SYNC edges later; reads
  // pop in order; a write into a full FIFO survives only if a read happens too.
  always @(posedge clk50m or negedge reset_n) begin
    bit rd, wr, full_before;
    logic [7:0] wd;
    if (!reset_n) begin
      mq.delete(); exp_rd.delete(); pend_at.delete(); pend_d.delete();
      m_rdv = 1'b0; mlast = 8'h00; movf = 1'b0; mlast_dok = 1'b0;
    end else begin
      edge_no++;
      wr = 1'b0;
      wd = 8'h00;
      if (pend_at.size() > 0 && pend_at[0] == edge_no) begin
        wr = 1'b1;
        wd = pend_d.pop_front();
        void'(pend_at.pop_front());
      end
      if (bus.dataok && !mlast_dok) begin
        pend_at.push_back(edge_no + SYNC);
        pend_d.push_back(bus.rxdata);
      end
      mlast_dok   = bus.dataok;
      rd          = bus.rd_en && (mq.size() > 0);
      full_before = (mq.size() == DEPTH);
      m_rdv       = rd;
      if (rd) begin
        mlast = mq.pop_front();
        exp_rd.push_back(mlast);
      end
      if (wr && (!full_before || rd)) mq.push_back(wd);
      if (wr && full_before && !rd) movf = 1'b1;
      else if (bus.ovf_clr) movf = 1'b0;
    end
  end

  // Monitor: compares DUT status every cycle and pops the scoreboard on rd_valid.
  always @(negedge clk50m) begin
    if (mon_en) begin
      check("mon_count",    int'(bus.count),    mq.size());
      check("mon_empty",    int'(bus.empty),    int'(mq.size() == 0));
      check("mon_full",     int'(bus.full),     int'(mq.size() == DEPTH));
      check("mon_overflow", int'(bus.overflow), int'(movf));
      check("mon_rd_valid", int'(bus.rd_valid), int'(m_rdv));
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_rd_data: got %0h with rd_valid, required no read (t=%0t)", bus.rd_data, $time);
        end else begin
          check("mon_rd_data", int'(bus.rd_data), int'(exp_rd.pop_front()));
        end
      end else begin
        check("mon_rd_hold", int'(bus.rd_data), int'(mlast));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, gap, pct;
    bus.rxdata  = 8'h00;
    bus.dataok  = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    tick(3);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick(2);
    check("rst_count",    int'(bus.count),    0);
    check("rst_empty",    int'(bus.empty),    1);
    check("rst_full",     int'(bus.full),     0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_rd_data",  int'(bus.rd_data),  0);

    // Single byte, dataok held 20 cycles: one write landing at edge N+2.
    bus.rxdata = 8'hA5;
    bus.dataok = 1'b1;
    tick(1);
    check("lat_edge_n_count", int'(bus.count), 0);
    tick(1);
    check("lat_edge_n1_count", int'(bus.count), 0);
    tick(1);
    check("lat_edge_n2_count", int'(bus.count), 1);
    check("lat_edge_n2_empty", int'(bus.empty), 0);
    tick(17);
    bus.dataok = 1'b0;
    tick(3);
    check("single_write_once", int'(bus.count), 1);
    read_n(1);
    check("single_rd_valid", int'(bus.rd_valid), 1);
    check("single_rd_data",  int'(bus.rd_data),  8'hA5);
    check("single_empty",    int'(bus.empty),    1);
    tick(1);
    check("single_rd_pulse", int'(bus.rd_valid), 0);

    // Fill and wrap.
    for (int i = 0; i < 16; i++) send(8'(i), 4, 3);
    check("fill_full",  int'(bus.full),  1);
    check("fill_count", int'(bus.count), 16);
    read_n(8);
    for (int i = 16; i < 24; i++) send(8'(i), 4, 3);
    check("wrap_count", int'(bus.count), 16);
    read_n(16);
    check("wrap_last_data", int'(bus.rd_data), 8'h17);
    tick(2);
    check("wrap_drained", int'(bus.count), 0);

    // Overflow.
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 4, 3);
    send(8'hEE, 4, 3);
    check("ovf_set",   int'(bus.overflow), 1);
    check("ovf_count", int'(bus.count),    16);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    check("ovf_clr", int'(bus.overflow), 0);
    bus.rxdata = 8'hE1;
    bus.dataok = 1'b1;
    tick(2);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    check("ovf_set_beats_clr", int'(bus.overflow), 1);
    tick(3);
    bus.dataok = 1'b0;
    tick(3);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;

    // Simultaneous write and read at full.
    bus.rxdata = 8'h77;
    bus.dataok = 1'b1;
    tick(2);
    read_n(1);
    check("full_rw_count",    int'(bus.count),    16);
    check("full_rw_overflow", int'(bus.overflow), 0);
    tick(3);
    bus.dataok = 1'b0;
    tick(3);
    read_n(16);
    check("full_rw_new_last", int'(bus.rd_data), 8'h77);
    tick(2);

    // Simultaneous write and read at empty.
    bus.rxdata = 8'h3C;
    bus.dataok = 1'b1;
    tick(2);
    read_n(1);
    check("empty_rw_rd_valid", int'(bus.rd_valid), 0);
    check("empty_rw_count",    int'(bus.count),    1);
    tick(3);
    bus.dataok = 1'b0;
    tick(3);
    read_n(1);
    check("empty_rw_data", int'(bus.rd_data), 8'h3C);
    tick(1);

    // Read while empty.
    bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rd_empty_valid", int'(bus.rd_valid), 0);
      check("rd_empty_data",  int'(bus.rd_data),  8'h3C);
      check("rd_empty_count", int'(bus.count),    0);
    end
    bus.rd_en = 1'b0;

    // Reset mid-operation, released with dataok high.
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 4, 3);
    check("pre_rst_count", int'(bus.count), 5);
    reset_n = 1'b0;
    #1;
    check("async_rst_count",    int'(bus.count),    0);
    check("async_rst_empty",    int'(bus.empty),    1);
    check("async_rst_full",     int'(bus.full),     0);
    check("async_rst_rd_valid", int'(bus.rd_valid), 0);
    check("async_rst_rd_data",  int'(bus.rd_data),  0);
    bus.rxdata = 8'h5A;
    bus.dataok = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(6);
    check("rst_release_write", int'(bus.count), 1);
    tick(10);
    check("rst_release_once", int'(bus.count), 1);
    bus.dataok = 1'b0;
    tick(3);
    read_n(1);
    check("rst_release_data", int'(bus.rd_data), 8'h5A);
    tick(2);

    // Randomised traffic in three read-pressure phases.
    hold = 0;
    gap  = 0;
    for (int c = 0; c < 3000; c++) begin
      pct = (c < 1000) ? 15 : ((c < 2000) ? 50 : 90);
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          bus.dataok = 1'b0;
          gap = $urandom_range(6, 2);
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        bus.rxdata = 8'($urandom);
        bus.dataok = 1'b1;
        hold = $urandom_range(10, 3);
      end
      bus.rd_en   = ($urandom_range(99, 0) < pct);
      bus.ovf_clr = ($urandom_range(99, 0) < 3);
      tick(1);
    end
    bus.dataok  = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    tick(4);
    read_n(20);
    tick(3);
    check("scoreboard_drained", exp_rd.size(), 0);
    check("final_count",        int'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
